scan_order_feeder: RTL and testbench

Tile buffer and scan sequencer that sits directly upstream of the all-directions edge detector. It accepts one N×N tile of 8-bit pixels in row-major order over a valid/ready handshake. It then streams the tile back out as paired beats: the row-major pixel drives `leftRightArray` and the transposed, column-major pixel drives `upDownArray`. It also generates the detector's `enb` and per-line `resetBuff` strobes.

---
 rtl/scan_order_feeder_pkg.sv | 20 ++
 rtl/tile_ram_2r1w.sv | 50 +++++
 rtl/scan_order_feeder.sv | 129 ++++++++++++
 tb/tb_scan_order_feeder.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/scan_order_feeder_pkg.sv
// rtl/scan_order_feeder_pkg.sv - shared types and helpers for the tile scan sequencer
//
// Holds the default pixel width, the sequencer state encoding and the
// helper that sizes tile index counters.

package scan_order_feeder_pkg;

  localparam int PIX_W_DEF = 8;

  typedef enum logic {
    LOAD   = 1'b0,
    STREAM = 1'b1
  } state_t;

  // Bits needed to address every pixel of an n x n tile.
  function automatic int idx_w(input int n);
    return $clog2(n * n);
  endfunction

endpackage

// File: rtl/tile_ram_2r1w.sv
// rtl/tile_ram_2r1w.sv - N x N pixel store with one write port and two synchronous read ports
//
// Ports:
//   clk, reset        clock, synchronous active-high reset (read registers only)
//   we, waddr, wdata  write port
//   re                read enable; when low the read registers keep their value
//   raddr_a, rdata_a  read port A (registered)
//   raddr_b, rdata_b  read port B (registered)

module tile_ram_2r1w
  import scan_order_feeder_pkg::*;
#(
  parameter int N     = 8,
  parameter int PIX_W = PIX_W_DEF,
  parameter int IW    = idx_w(N)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             we,
  input  logic [IW-1:0]    waddr,
  input  logic [PIX_W-1:0] wdata,
  input  logic             re,
  input  logic [IW-1:0]    raddr_a,
  input  logic [IW-1:0]    raddr_b,
  output logic [PIX_W-1:0] rdata_a,
  output logic [PIX_W-1:0] rdata_b
);

  logic [PIX_W-1:0] mem [N*N];

  // Storage is deliberately not reset so it maps onto distributed RAM.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  // Read registers double as the block's output registers, so they reset
  // to zero and hold their value while reads are not issued.
  always_ff @(posedge clk) begin
    if (reset) begin
      rdata_a <= '0;
      rdata_b <= '0;
    end else if (re) begin
      rdata_a <= mem[raddr_a];
      rdata_b <= mem[raddr_b];
    end
  end

endmodule

// File: rtl/scan_order_feeder.sv
// rtl/scan_order_feeder.sv - tile buffer streaming row-major and column-major pixel pairs
//
// Ports:
//   clk, reset        clock, synchronous active-high reset
//   in_valid/in_ready/in_pixel   row-major tile input handshake
//   hold              downstream stall, freezes the scan
//   leftRightArray    pixel (r, c) of the current beat
//   upDownArray       pixel (c, r) of the current beat
//   enb               beat valid
//   resetBuff         first beat of a line (c == 0)
//   last              final beat of the tile
//   busy              high while streaming

module scan_order_feeder
  import scan_order_feeder_pkg::*;
#(
  parameter int N     = 8,
  parameter int PIX_W = PIX_W_DEF
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_pixel,
  input  logic             hold,
  output logic [PIX_W-1:0] leftRightArray,
  output logic [PIX_W-1:0] upDownArray,
  output logic             enb,
  output logic             resetBuff,
  output logic             last,
  output logic             busy
);

  localparam int            IW       = idx_w(N);
  localparam logic [IW-1:0] LAST_IDX = IW'(N * N - 1);
  localparam logic [IW-1:0] LAST_RC  = IW'(N - 1);
  localparam logic [IW-1:0] N_IW     = IW'(N);

  state_t        state;
  logic [IW-1:0] wr_idx;
  logic [IW-1:0] r;
  logic [IW-1:0] c;
  logic          drained;  // final read issued; waiting for it to reach the outputs
  logic          issue;
  logic          we;
  logic [IW-1:0] raddr_a;
  logic [IW-1:0] raddr_b;

  assign in_ready = (state == LOAD);
  assign busy     = (state == STREAM);
  assign we       = in_valid && (state == LOAD);
  assign issue    = (state == STREAM) && !hold && !drained;

  // r, c <= N-1, so both products stay within N*N-1 at index width.
  assign raddr_a  = r * N_IW + c;
  assign raddr_b  = c * N_IW + r;

  tile_ram_2r1w #(
    .N     (N),
    .PIX_W (PIX_W),
    .IW    (IW)
  ) u_ram (
    .clk     (clk),
    .reset   (reset),
    .we      (we),
    .waddr   (wr_idx),
    .wdata   (in_pixel),
    .re      (issue),
    .raddr_a (raddr_a),
    .raddr_b (raddr_b),
    .rdata_a (leftRightArray),
    .rdata_b (upDownArray)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state     <= LOAD;
      wr_idx    <= '0;
      r         <= '0;
      c         <= '0;
      drained   <= 1'b0;
      enb       <= 1'b0;
      resetBuff <= 1'b0;
      last      <= 1'b0;
    end else begin
      // Strobes describe the beat whose read is issued this cycle; they
      // line up with the pixel data one cycle later.
      enb       <= issue;
      resetBuff <= issue && (c == '0);
      last      <= issue && (r == LAST_RC) && (c == LAST_RC);

      case (state)
        LOAD: begin
          if (in_valid) begin
            if (wr_idx == LAST_IDX) begin
              wr_idx  <= '0;
              r       <= '0;
              c       <= '0;
              drained <= 1'b0;
              state   <= STREAM;
            end else begin
              wr_idx <= wr_idx + IW'(1);
            end
          end
        end
        STREAM: begin
          if (drained) begin
            drained <= 1'b0;
            state   <= LOAD;
          end else if (issue) begin
            if (c == LAST_RC) begin
              c <= '0;
              if (r == LAST_RC) begin
                r       <= '0;
                drained <= 1'b1;
              end else begin
                r <= r + IW'(1);
              end
            end else begin
              c <= c + IW'(1);
            end
          end
        end
        default: state <= LOAD;
      endcase
    end
  end

endmodule

// File: tb/tb_scan_order_feeder.sv
// tb/tb_scan_order_feeder.sv - scoreboard bench for the N=4 tile scan sequencer

module tb_scan_order_feeder;

  localparam int N = 4;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       in_valid = 1'b0;
  logic [7:0] in_pixel = '0;
  logic       hold = 1'b0;
  logic       in_ready;
  logic [7:0] leftRightArray;
  logic [7:0] upDownArray;
  logic       enb;
  logic       resetBuff;
  logic       last;
  logic       busy;

  typedef struct packed {
    logic [7:0] lr;
    logic [7:0] ud;
    logic       rb;
    logic       lst;
  } beat_t;

  beat_t q[$];
  int    checks = 0;
  int    failures = 0;
  int    ud_ord [16] = '{0, 4, 8, 12, 1, 5, 9, 13, 2, 6, 10, 14, 3, 7, 11, 15};
  logic [7:0] cur_tile [16];

  scan_order_feeder #(.N(N), .PIX_W(8)) dut (
    .clk            (clk),
    .reset          (reset),
    .in_valid       (in_valid),
    .in_ready       (in_ready),
    .in_pixel       (in_pixel),
    .hold           (hold),
    .leftRightArray (leftRightArray),
    .upDownArray    (upDownArray),
    .enb            (enb),
    .resetBuff      (resetBuff),
    .last           (last),
    .busy           (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic push_tile();
    for (int k = 0; k < 16; k++) begin
      beat_t b;
      b.lr  = cur_tile[k];
      b.ud  = cur_tile[ud_ord[k]];
      b.rb  = ((k % 4) == 0);
      b.lst = (k == 15);
      q.push_back(b);
    end
  endtask

  task automatic load_tile(input bit gaps, input bit keep_valid);
    for (int i = 0; i < 16; i++) begin
      if (gaps && ($urandom_range(0, 1) == 1)) begin
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        check("in_ready_gap", int'(in_ready), 1);
      end
      in_valid = 1'b1;
      in_pixel = cur_tile[i];
      check("in_ready_load", int'(in_ready), 1);
      @(posedge clk);
      #1;
    end
    if (keep_valid) in_pixel = 8'hEE;
    else in_valid = 1'b0;
  endtask

  task automatic wait_ready(input string name);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!in_ready && n < 100);
    if (!in_ready) check(name, 0, 1);
    check("queue_drained", q.size(), 0);
  endtask

  task automatic wait_beats(input int count);
    int seen;
    int n;
    seen = 0;
    n = 0;
    while (seen < count && n < 100) begin
      @(negedge clk);
      n++;
      if (enb) seen++;
    end
    check("beat_wait_timeout", seen, count);
  endtask

  // Monitor: every presented beat must match the head of the scoreboard.
  always @(negedge clk) begin
    if (!reset) begin
      if (enb) begin
        if (q.size() == 0) begin
          check("unexpected_beat", 1, 0);
        end else begin
          beat_t e;
          e = q.pop_front();
          check("lr_pixel", int'(leftRightArray), int'(e.lr));
          check("ud_pixel", int'(upDownArray), int'(e.ud));
          check("resetBuff", int'(resetBuff), int'(e.rb));
          check("last", int'(last), int'(e.lst));
        end
      end else if (resetBuff || last) begin
        check("strobe_without_enb", int'(resetBuff) + int'(last), 0);
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got 1 expected 0");
    $fatal(1, "timeout");
  end

  initial begin
    int cnt;

    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_in_ready", int'(in_ready), 1);
    check("rst_enb", int'(enb), 0);
    check("rst_busy", int'(busy), 0);
    check("rst_lr", int'(leftRightArray), 0);
    check("rst_ud", int'(upDownArray), 0);
    check("rst_strobes", int'(resetBuff) + int'(last), 0);

    // Tile 0..15, no gaps, first-beat latency.
    for (int i = 0; i < 16; i++) cur_tile[i] = 8'(i);
    push_tile();
    load_tile(1'b0, 1'b0);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!enb && cnt < 10);
    check("first_enb_latency", cnt, 2);
    check("busy_streaming", int'(busy), 1);
    wait_ready("tile1_done");

    // Same tile with random input gaps.
    push_tile();
    load_tile(1'b1, 1'b0);
    wait_ready("gaps_done");

    // Hold for 3 cycles at beat 6.
    push_tile();
    load_tile(1'b0, 1'b0);
    wait_beats(6);
    hold = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("hold_gap_enb", int'(enb), 0);
    end
    hold = 1'b0;
    @(negedge clk);
    check("post_hold_enb", int'(enb), 1);
    check("post_hold_lr", int'(leftRightArray), 6);
    check("post_hold_ud", int'(upDownArray), 9);
    wait_ready("hold_done");

    // in_valid held high throughout streaming.
    push_tile();
    load_tile(1'b0, 1'b1);
    for (int k = 0; k < 17; k++) begin
      @(negedge clk);
      check("in_ready_stream", int'(in_ready), 0);
    end
    @(negedge clk);
    check("in_ready_after_stream", int'(in_ready), 1);
    in_valid = 1'b0;
    check("queue_drained_valid", q.size(), 0);

    // Reset at beat 9, then a fresh tile 100..115.
    push_tile();
    load_tile(1'b0, 1'b0);
    wait_beats(10);
    reset = 1'b1;
    @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("abort_enb", int'(enb), 0);
    check("abort_in_ready", int'(in_ready), 1);
    q.delete();
    for (int i = 0; i < 16; i++) cur_tile[i] = 8'(100 + i);
    push_tile();
    load_tile(1'b0, 1'b0);
    wait_ready("after_reset_done");

    // Back-to-back tiles.
    for (int i = 0; i < 16; i++) cur_tile[i] = 8'(50 + 3 * i);
    push_tile();
    load_tile(1'b0, 1'b0);
    cnt = 0;
    do begin
      @(negedge clk);
      cnt++;
    end while (!(enb && last) && cnt < 100);
    check("last_seen", int'(last), 1);
    check("in_ready_at_last", int'(in_ready), 0);
    @(negedge clk);
    check("in_ready_after_last", int'(in_ready), 1);
    for (int i = 0; i < 16; i++) cur_tile[i] = 8'(255 - i);
    push_tile();
    load_tile(1'b0, 1'b0);
    wait_ready("b2b_done");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
